// File: rtl/dual_issue_pkg.sv
// Shared types and helpers for the dual-issue scheduler.
package dual_issue_pkg;

   localparam int REG_W = 5;
   localparam int LAT_W = 3;

   typedef enum logic {PAIR, HALF} state_t;

   // Register 0 is hard-wired zero, so it can never be pending.
   function automatic logic op_hazard(input logic [REG_W-1:0] r, input logic busy);
      return (r != '0) && busy;
   endfunction

endpackage

// File: rtl/dual_issue_ctrl_scoreboard.sv
// Per-register write-latency counters with two issue load ports.
module issue_scoreboard
   import dual_issue_pkg::*;
#(
   parameter int WB_LAT = 2,
   parameter int NREGS  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld0,
   input  logic [REG_W-1:0] ld0_rd,
   input  logic             ld1,
   input  logic [REG_W-1:0] ld1_rd,
   output logic [NREGS-1:0] busy_mask
);

   localparam logic [LAT_W-1:0] LAT = LAT_W'(WB_LAT);

   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      logic [LAT_W-1:0] cnt;
      logic             hit;

      assign hit = (r != 0) && ((ld0 && ld0_rd == REG_W'(r)) || (ld1 && ld1_rd == REG_W'(r)));

      // A fresh load wins over the countdown.
      always_ff @(posedge clk) begin
         if (rst)             cnt <= '0;
         else if (hit)        cnt <= LAT;
         else if (cnt != '0)  cnt <= cnt - 1'b1;
      end

      assign busy_mask[r] = !rst && (cnt != '0);
   end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Two-slot issue scheduler; splits bundles on hazards.
// Optional DUAL_ISSUE_STATS_EN adds saturating stall/split counters.
module dual_issue_ctrl
   import dual_issue_pkg::*;
#(
   parameter int WB_LAT = 2,
   parameter int NREGS  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_valid,
   input  logic [REG_W-1:0] s0_rs1,
   input  logic [REG_W-1:0] s0_rs2,
   input  logic [REG_W-1:0] s0_rd,
   input  logic             s0_wr,
   input  logic             s0_mem,
   input  logic             s1_valid,
   input  logic [REG_W-1:0] s1_rs1,
   input  logic [REG_W-1:0] s1_rs2,
   input  logic [REG_W-1:0] s1_rd,
   input  logic             s1_wr,
   input  logic             s1_mem,
   output logic             issue0,
   output logic             issue1,
   output logic [1:0]       pc_step,
   output logic             stall,
   output logic [NREGS-1:0] busy_mask
`ifdef DUAL_ISSUE_STATS_EN
   ,output logic [31:0]     stall_cnt,
   output logic [31:0]      split_cnt
`endif
);

   state_t state;
   logic   s0_haz, s1_haz, raw, waw, s1_ok, split;

   assign s0_haz = op_hazard(s0_rs1, busy_mask[s0_rs1]) || op_hazard(s0_rs2, busy_mask[s0_rs2]);
   assign s1_haz = op_hazard(s1_rs1, busy_mask[s1_rs1]) || op_hazard(s1_rs2, busy_mask[s1_rs2]);
   assign raw    = s0_wr && (s0_rd != '0) && (s1_rs1 == s0_rd || s1_rs2 == s0_rd);
   assign waw    = s0_wr && s1_wr && (s0_rd == s1_rd);
   assign s1_ok  = !s1_haz && !raw && !waw && !(s0_mem && s1_mem);

   always_comb begin
      issue0  = 1'b0;
      issue1  = 1'b0;
      pc_step = 2'd0;
      stall   = 1'b0;
      split   = 1'b0;
      if (!rst && fetch_valid) begin
         if (state == PAIR) begin
            if (s0_haz) begin
               stall = 1'b1;
            end else begin
               issue0 = 1'b1;
               if (s1_valid && s1_ok) begin
                  issue1  = 1'b1;
                  pc_step = 2'd2;
               end else if (!s1_valid) begin
                  pc_step = 2'd2;
               end else begin
                  split = 1'b1;
               end
            end
         end else begin
            // Slot 0 already went; only slot 1 of the held bundle remains.
            if (!s1_haz) begin
               issue1  = 1'b1;
               pc_step = 2'd2;
            end else begin
               stall = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                           state <= PAIR;
      else if (split)                    state <= HALF;
      else if (state == HALF && issue1)  state <= PAIR;
   end

   issue_scoreboard #(.WB_LAT(WB_LAT), .NREGS(NREGS)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .ld0       (issue0 && s0_wr && s0_rd != '0),
      .ld0_rd    (s0_rd),
      .ld1       (issue1 && s1_wr && s1_rd != '0),
      .ld1_rd    (s1_rd),
      .busy_mask (busy_mask)
   );

`ifdef DUAL_ISSUE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         split_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (split && split_cnt != '1) split_cnt <= split_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard-driven bench for dual_issue_ctrl (WB_LAT=2 and WB_LAT=0 instances).
module tb_dual_issue_ctrl;

   logic clk = 1'b0;
   logic rst, rst0;
   logic fetch_valid, s0_wr, s0_mem, s1_valid, s1_wr, s1_mem;
   logic [4:0] s0_rs1, s0_rs2, s0_rd, s1_rs1, s1_rs2, s1_rd;
   logic issue0, issue1, stall, z_issue0, z_issue1, z_stall;
   logic [1:0] pc_step, z_pc_step;
   logic [31:0] busy_mask, z_busy_mask;
`ifdef DUAL_ISSUE_STATS_EN
   logic [31:0] stall_cnt, split_cnt, z_stall_cnt, z_split_cnt;
`endif

   always #5 clk = ~clk;

   dual_issue_ctrl #(.WB_LAT(2), .NREGS(32)) dut (
      .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
      .s0_rs1(s0_rs1), .s0_rs2(s0_rs2), .s0_rd(s0_rd), .s0_wr(s0_wr), .s0_mem(s0_mem),
      .s1_valid(s1_valid), .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rd(s1_rd),
      .s1_wr(s1_wr), .s1_mem(s1_mem),
      .issue0(issue0), .issue1(issue1), .pc_step(pc_step), .stall(stall),
      .busy_mask(busy_mask)
`ifdef DUAL_ISSUE_STATS_EN
      , .stall_cnt(stall_cnt), .split_cnt(split_cnt)
`endif
   );

   dual_issue_ctrl #(.WB_LAT(0), .NREGS(32)) dut0 (
      .clk(clk), .rst(rst0), .fetch_valid(fetch_valid),
      .s0_rs1(s0_rs1), .s0_rs2(s0_rs2), .s0_rd(s0_rd), .s0_wr(s0_wr), .s0_mem(s0_mem),
      .s1_valid(s1_valid), .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rd(s1_rd),
      .s1_wr(s1_wr), .s1_mem(s1_mem),
      .issue0(z_issue0), .issue1(z_issue1), .pc_step(z_pc_step), .stall(z_stall),
      .busy_mask(z_busy_mask)
`ifdef DUAL_ISSUE_STATS_EN
      , .stall_cnt(z_stall_cnt), .split_cnt(z_split_cnt)
`endif
   );

   typedef struct packed {
      logic fv;
      logic [4:0] a1, a2, ad; logic aw, am;
      logic bv;
      logic [4:0] b1, b2, bd; logic bw, bm;
   } bun_t;

   typedef struct packed {
      logic i0, i1; logic [1:0] ps; logic st; logic [31:0] bm;
   } obs_t;

   obs_t q[$];
   int checks = 0;
   int errors = 0;
   bun_t IDLE, IND, RAW, WAW, MEM, R0, WR8, RD8;

   function automatic bun_t mk(int a1, int a2, int ad, bit aw, bit am,
                               bit bv, int b1, int b2, int bd, bit bw, bit bm);
      bun_t b;
      b = '{1'b1, 5'(a1), 5'(a2), 5'(ad), aw, am, bv, 5'(b1), 5'(b2), 5'(bd), bw, bm};
      return b;
   endfunction

   function automatic obs_t ex(bit i0, bit i1, int ps, bit st, logic [31:0] bm);
      obs_t o;
      o = '{i0, i1, 2'(ps), st, bm};
      return o;
   endfunction

   function automatic logic [31:0] rb(int r);
      return 32'd1 << r;
   endfunction

   function automatic obs_t cur(bit lat0);
      return lat0 ? '{z_issue0, z_issue1, z_pc_step, z_stall, z_busy_mask}
                  : '{issue0, issue1, pc_step, stall, busy_mask};
   endfunction

   // Applies one cycle of stimulus and queues what the DUT must show for it.
   task automatic drive(input bun_t b, input logic r, input logic r0, input obs_t e);
      @(negedge clk);
      rst = r; rst0 = r0;
      {fetch_valid, s0_rs1, s0_rs2, s0_rd, s0_wr, s0_mem,
       s1_valid, s1_rs1, s1_rs2, s1_rd, s1_wr, s1_mem} = b;
      q.push_back(e);
      #2;
   endtask

   task automatic test_reset();
      obs_t got, e;
      for (int i = 0; i < 2; i++) begin
         drive(IND, 1'b1, 1'b1, ex(0, 0, 0, 0, 0));
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL reset cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_independent();
      bun_t b[4] = '{IND, IDLE, IDLE, IDLE};
      obs_t ev[4] = '{ex(1,1,2,0,0), ex(0,0,0,0,rb(3)|rb(6)), ex(0,0,0,0,rb(3)|rb(6)), ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 4; i++) begin
         drive(b[i], 1'b0, 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL independent cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_reg0();
      bun_t b[2] = '{R0, IDLE};
      obs_t ev[2] = '{ex(1,1,2,0,0), ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 2; i++) begin
         drive(b[i], 1'b0, 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL reg0 cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_s0_hazard();
      bun_t b[7] = '{WR8, RD8, RD8, RD8, IDLE, IDLE, IDLE};
      obs_t ev[7] = '{ex(1,0,2,0,0), ex(0,0,0,1,rb(8)), ex(0,0,0,1,rb(8)), ex(1,0,2,0,0),
                      ex(0,0,0,0,rb(9)), ex(0,0,0,0,rb(9)), ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 7; i++) begin
         drive(b[i], 1'b0, 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL s0_hazard cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_raw();
      bun_t b[7] = '{RAW, RAW, RAW, RAW, IDLE, IDLE, IDLE};
      obs_t ev[7] = '{ex(1,0,0,0,0), ex(0,0,0,1,rb(3)), ex(0,0,0,1,rb(3)), ex(0,1,2,0,0),
                      ex(0,0,0,0,rb(5)), ex(0,0,0,0,rb(5)), ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 7; i++) begin
         drive(b[i], 1'b0, 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL raw cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_half_hold();
      bun_t b[7] = '{RAW, IDLE, RAW, RAW, IDLE, IDLE, IDLE};
      obs_t ev[7] = '{ex(1,0,0,0,0), ex(0,0,0,0,rb(3)), ex(0,0,0,1,rb(3)), ex(0,1,2,0,0),
                      ex(0,0,0,0,rb(5)), ex(0,0,0,0,rb(5)), ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 7; i++) begin
         drive(b[i], 1'b0, 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL half_hold cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_raw_lat0();
      bun_t b[3] = '{RAW, RAW, IDLE};
      obs_t ev[3] = '{ex(1,0,0,0,0), ex(0,1,2,0,0), ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 3; i++) begin
         drive(b[i], 1'b1, 1'b0, ev[i]);
         got = cur(1); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL raw_lat0 cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_waw();
      bun_t b[5] = '{WAW, WAW, IDLE, IDLE, IDLE};
      obs_t ev[5] = '{ex(1,0,0,0,0), ex(0,1,2,0,rb(7)), ex(0,0,0,0,rb(7)), ex(0,0,0,0,rb(7)),
                      ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 5; i++) begin
         drive(b[i], 1'b0, 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL waw cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_dual_mem();
      bun_t b[5] = '{MEM, MEM, IDLE, IDLE, IDLE};
      obs_t ev[5] = '{ex(1,0,0,0,0), ex(0,1,2,0,rb(3)), ex(0,0,0,0,rb(3)|rb(6)), ex(0,0,0,0,rb(6)),
                      ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 5; i++) begin
         drive(b[i], 1'b0, 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL dual_mem cyc %0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_reset_half();
      bun_t b[7] = '{RAW, RAW, IDLE, IND, IDLE, IDLE, IDLE};
      logic rs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      obs_t ev[7] = '{ex(1,0,0,0,0), ex(0,0,0,0,0), ex(0,0,0,0,0), ex(1,1,2,0,0),
                      ex(0,0,0,0,rb(3)|rb(6)), ex(0,0,0,0,rb(3)|rb(6)), ex(0,0,0,0,0)};
      obs_t got, e;
      for (int i = 0; i < 7; i++) begin
         drive(b[i], rs[i], 1'b1, ev[i]);
         got = cur(0); e = q.pop_front(); checks++;
         if (got !== e) begin errors++; $display("FAIL reset_half cyc %0d got=%h exp=%h", i, got, e); end
`ifdef DUAL_ISSUE_STATS_EN
         if (i == 2) begin
            checks++;
            if (stall_cnt !== 32'd0 || split_cnt !== 32'd0) begin
               errors++;
               $display("FAIL reset_half stats got stall=%0d split=%0d exp 0/0", stall_cnt, split_cnt);
            end
         end
`endif
      end
   endtask

   initial begin
      IDLE = '0;
      IND  = mk(1, 2, 3, 1, 0,  1, 4, 5, 6, 1, 0);
      RAW  = mk(1, 2, 3, 1, 0,  1, 3, 4, 5, 1, 0);
      WAW  = mk(1, 2, 7, 1, 0,  1, 4, 5, 7, 1, 0);
      MEM  = mk(1, 2, 3, 1, 1,  1, 4, 5, 6, 1, 1);
      R0   = mk(1, 2, 0, 1, 0,  1, 0, 0, 9, 0, 0);
      WR8  = mk(1, 2, 8, 1, 0,  0, 0, 0, 0, 0, 0);
      RD8  = mk(8, 0, 9, 1, 0,  0, 0, 0, 0, 0, 0);
      rst = 1'b1; rst0 = 1'b1;
      {fetch_valid, s0_rs1, s0_rs2, s0_rd, s0_wr, s0_mem,
       s1_valid, s1_rs1, s1_rs2, s1_rd, s1_wr, s1_mem} = IDLE;

      test_reset();
      test_independent();
      test_reg0();
      test_s0_hazard();
      test_raw();
      test_half_hold();
      test_raw_lat0();
      test_waw();
      test_dual_mem();
      test_reset_half();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
- Issue scheduler for the two-slot core.
- Sits between the decoder and the register file / two ALUs.
- Each cycle it receives the decoded register fields of the fetched instruction pair. It decides whether slot 0, slot 1, both, or neither issue, and by how many instructions the PC advances.
- Tracks in-flight register writes with a scoreboard. Splits a bundle across cycles on intra-bundle RAW, WAW or dual-memory conflicts.

Parameters:
- WB_LAT, 2, cycles from issue until the written value is readable by a dependent instruction; legal 0..7.
- NREGS, 32, architectural register count; register 0 is hard-wired zero and never causes a hazard.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- fetch_valid  in  1  decoded bundle present this cycle
- s0_rs1, s0_rs2, s0_rd  in  5 each  slot 0 source and destination registers
- s0_wr  in  1  slot 0 writes s0_rd
- s0_mem  in  1  slot 0 is a load or store
- s1_valid  in  1  slot 1 holds a real instruction; 0 means nop
- s1_rs1, s1_rs2, s1_rd  in  5 each  slot 1 source and destination registers
- s1_wr, s1_mem  in  1 each  same meaning as for slot 0
- issue0  out  1  slot 0 issues this cycle
- issue1  out  1  slot 1 issues this cycle; drives the second ALU enable
- pc_step  out  2  instructions to advance the PC: 0 or 2
- stall  out  1  fetch_valid high and nothing issues this cycle
- busy_mask  out  NREGS  bit r set while cnt[r] != 0

Behaviour:
- issue0, issue1, pc_step and stall are combinational from the current state, the scoreboard and the inputs. State and scoreboard update on the rising edge of clk.
- Reset: state=PAIR, all cnt[r]=0. While rst=1: issue0=issue1=stall=0, pc_step=0, busy_mask=0.
- Hazard on operand r: r != 0 and cnt[r] != 0.
- State PAIR:
  - fetch_valid=0: no issue; pc_step=0; stall=0.
  - Any slot 0 source has a hazard: stall=1, no issue, pc_step=0.
  - Otherwise issue0=1. issue1=1 when s1_valid is high and all of the following hold:
    - no scoreboard hazard on s1_rs1 or s1_rs2;
    - no intra-bundle RAW: s0_wr, s0_rd != 0, and s1_rs1 or s1_rs2 == s0_rd;
    - no WAW: s0_wr, s1_wr and s0_rd == s1_rd;
    - not (s0_mem and s1_mem).
  - If slot 1 issued or s1_valid=0: pc_step=2, stay in PAIR.
  - Otherwise: pc_step=0, next state HALF.
- State HALF (slot 0 of the held bundle already issued; fetch holds the same bundle):
  - issue0=0.
  - issue1=1 when s1 has no scoreboard hazard; then pc_step=2 and next state PAIR.
  - Otherwise stall=1, pc_step=0.
- Scoreboard, per register:
  - On issue of a slot with wr=1 and rd != 0, cnt[rd] is loaded with WB_LAT.
  - Otherwise a nonzero cnt decrements by 1 each cycle.
  - A load beats a decrement in the same cycle.
- WB_LAT=0: scoreboard is never nonzero. Intra-bundle RAW/WAW/mem conflicts still split, and slot 1 issues the next cycle.
- Reset mid-HALF: the pending slot 1 is dropped, state returns to PAIR, scoreboard is cleared.
- fetch_valid low while in HALF: hold HALF with no issue. The decoder holds the bundle stable.

Optional Feature:
- Macro DUAL_ISSUE_STATS_EN.
- Defined: adds 32-bit outputs stall_cnt (cycles with stall=1) and split_cnt (PAIR->HALF transitions). Both reset to 0, are synchronous and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dual_issue_pkg holds:
  - REG_W=5;
  - LAT_W=3;
  - state enum {PAIR, HALF};
  - a function for operand hazard detection.
- Sub-module issue_scoreboard holds the per-register counters, the two load ports and busy_mask, instantiated once.

Test Plan:
- Reset: rst=1 for 2 cycles with fetch_valid=1 -> issue0=issue1=0, pc_step=0, busy_mask=0.
- Independent pair {r3=r1+r2, r6=r4+r5}, WB_LAT=2 -> same cycle issue0=issue1=1, pc_step=2. busy_mask bits 3 and 6 stay set for 2 cycles, then clear.
- Intra RAW {r3=r1+r2, r5=r3+r4}, WB_LAT=2:
  - cycle 0: issue0=1, issue1=0, pc_step=0;
  - cycles 1-2: stall=1;
  - cycle 3: issue1=1, pc_step=2.
  - With WB_LAT=0, issue1 comes at cycle 1.
- WAW (both rd=7) and dual-mem (s0_mem=s1_mem=1, independent regs) -> split. issue1 comes one cycle after issue0 for the dual-mem case.
- Register 0: s0 writes r0, s1 reads r0 -> both issue in the same cycle, busy_mask=0.
- rst asserted during HALF -> next cycle state PAIR, issue1 never asserted for the dropped bundle, busy_mask=0. With DUAL_ISSUE_STATS_EN, stall_cnt=split_cnt=0.
